// File: rtl/mac_seq_pkg.sv
// Shared definitions for the sequential multiply-accumulate block.
package mac_seq_pkg;

   localparam int unsigned DefWidth    = 8;
   localparam int unsigned DefAccWidth = 32;
   localparam int unsigned DefLenW     = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } mac_state_e;

endpackage

// File: rtl/mac_dp.sv
// Combinational multiply-accumulate: sum = acc + weight*inp, with carry-out.
module mac_dp
   import mac_seq_pkg::*;
#(
   parameter int unsigned WIDTH    = DefWidth,
   parameter int unsigned ACCWIDTH = DefAccWidth
) (
   input  logic [WIDTH-1:0]    weight,
   input  logic [WIDTH-1:0]    inp,
   input  logic [ACCWIDTH-1:0] acc,
   output logic [ACCWIDTH-1:0] sum,
   output logic                carry
);

   logic [2*WIDTH-1:0] prod;
   logic [ACCWIDTH:0]  prod_ext;
   logic [ACCWIDTH:0]  total;

   // Full-width product, zero-extended one bit past the accumulator to expose the carry.
   always_comb begin
      prod     = weight * inp;
      prod_ext = {{(ACCWIDTH + 1 - 2 * WIDTH){1'b0}}, prod};
      total    = {1'b0, acc} + prod_ext;
      sum      = total[ACCWIDTH-1:0];
      carry    = total[ACCWIDTH];
   end

endmodule

// File: rtl/mac_seq.sv
// Sequential dot-product engine: loads bias, accumulates len weight*inp beats,
// then presents the result until the consumer takes it.
module mac_seq
   import mac_seq_pkg::*;
#(
   parameter int unsigned WIDTH    = DefWidth,
   parameter int unsigned ACCWIDTH = DefAccWidth,
   parameter int unsigned LENW     = DefLenW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [LENW-1:0]     len,
   input  logic [ACCWIDTH-1:0] bias,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    weight,
   input  logic [WIDTH-1:0]    inp,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ACCWIDTH-1:0] result,
   output logic                ovf,
   output logic                busy
);

   mac_state_e          state_q, state_d;
   logic [ACCWIDTH-1:0] acc_q, acc_d;
   logic [LENW-1:0]     cnt_q, cnt_d;
   logic                ovf_q, ovf_d;

   logic [ACCWIDTH-1:0] dp_sum;
   logic                dp_carry;

   mac_dp #(
      .WIDTH    (WIDTH),
      .ACCWIDTH (ACCWIDTH)
   ) u_mac_dp (
      .weight (weight),
      .inp    (inp),
      .acc    (acc_q),
      .sum    (dp_sum),
      .carry  (dp_carry)
   );

   // Next-state: job load in idle, beat accumulation in run, handoff in done.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               acc_d   = bias;
               cnt_d   = len;
               ovf_d   = 1'b0;
               state_d = (len == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            // in_ready is 1 throughout run, so in_valid alone qualifies a beat.
            if (in_valid) begin
               acc_d = dp_sum;
               cnt_d = cnt_q - LENW'(1);
               if (dp_carry) begin
                  ovf_d = 1'b1;
               end
               if (cnt_q == LENW'(1)) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset aborts any job in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Handshake and status outputs are pure functions of state.
   always_comb begin
      in_ready  = (state_q == StRun);
      out_valid = (state_q == StDone);
      busy      = (state_q != StIdle);
      result    = acc_q;
      ovf       = ovf_q;
   end

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq: the driver pushes model results, a monitor pops on handshake.
module tb_mac_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  len;
   logic [31:0] bias;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  weight;
   logic [7:0]  inp;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        ovf;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int beat_cnt = 0;

   logic [32:0] exp_q[$];
   logic [7:0]  w_arr[256];
   logic [7:0]  i_arr[256];

   mac_seq #(
      .WIDTH    (8),
      .ACCWIDTH (32),
      .LENW     (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .bias      (bias),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .weight    (weight),
      .inp       (inp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: bias plus the sum of products, wrapping at 2^32, with a sticky wrap flag.
   function automatic logic [32:0] model(input int n, input logic [31:0] b);
      longint a = longint'(b);
      bit     o = 1'b0;
      for (int k = 0; k < n; k++) begin
         a = a + longint'(w_arr[k]) * longint'(i_arr[k]);
         if (a >= 64'h1_0000_0000) begin
            a = a - 64'h1_0000_0000;
            o = 1'b1;
         end
      end
      return {o, a[31:0]};
   endfunction

   // Monitor: beat counting, result stability while stalled, scoreboard pop on handshake.
   logic        have_prev = 1'b0;
   logic [32:0] prev_out;
   always @(negedge clk) begin
      logic [32:0] e;
      if (in_valid && in_ready) beat_cnt++;
      if (out_valid) begin
         if (have_prev) chk("done_stable", {ovf, result}, prev_out);
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("result", result, e[31:0]);
               chk("ovf", ovf, e[32]);
            end
            have_prev = 1'b0;
         end else begin
            have_prev = 1'b1;
            prev_out  = {ovf, result};
         end
      end else begin
         have_prev = 1'b0;
      end
   end

   // One full job: start, beats with idle gaps, stalled done, release. Expects FSM idle on entry.
   task automatic do_job(input int n, input logic [31:0] b, input int gmin, input int gmax,
                         input int hmin, input int hmax);
      longint part;
      int     beats0;
      int     g;
      int     h;
      start = 1'b1;
      len   = n[7:0];
      bias  = b;
      @(posedge clk); #1;
      start  = 1'b0;
      exp_q.push_back(model(n, b));
      beats0 = beat_cnt;
      part   = longint'(b);
      if (n == 0) begin
         chk("len0_out_valid", out_valid, 1'b1);
         chk("len0_in_ready", in_ready, 1'b0);
      end
      for (int k = 0; k < n; k++) begin
         g = int'($urandom_range(gmax, gmin));
         repeat (g) begin
            chk("gap_hold", result, part[31:0]);
            start = 1'($urandom_range(1, 0));
            len   = 8'($urandom);
            bias  = $urandom;
            @(posedge clk); #1;
            start = 1'b0;
         end
         chk("pre_beat_out_valid", out_valid, 1'b0);
         chk("run_in_ready", in_ready, 1'b1);
         in_valid = 1'b1;
         weight   = w_arr[k];
         inp      = i_arr[k];
         @(posedge clk); #1;
         in_valid = 1'b0;
         part = part + longint'(w_arr[k]) * longint'(i_arr[k]);
         if (part >= 64'h1_0000_0000) part = part - 64'h1_0000_0000;
         chk("beat_acc", result, part[31:0]);
      end
      chk("done_out_valid", out_valid, 1'b1);
      chk("done_in_ready", in_ready, 1'b0);
      h = int'($urandom_range(hmax, hmin));
      repeat (h) begin
         start = 1'b1;
         len   = 8'($urandom);
         bias  = $urandom;
         @(posedge clk); #1;
         start = 1'b0;
         chk("done_hold_busy", busy, 1'b1);
      end
      out_ready = 1'b1;
      start     = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      out_ready = 1'b0;
      start     = 1'b0;
      chk("back_idle", {busy, out_valid, in_ready}, 3'b000);
      chk("beat_count", beat_cnt - beats0, n);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      len       = '0;
      bias      = '0;
      in_valid  = 1'b0;
      weight    = '0;
      inp       = '0;
      out_ready = 1'b0;
      #1;
      chk("reset_outputs", {busy, in_ready, out_valid, ovf, result}, 36'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_outputs", {busy, in_ready, out_valid, ovf, result}, 36'h0);

      // Three back-to-back beats on a small bias.
      w_arr[0] = 8'd2; i_arr[0] = 8'd3;
      w_arr[1] = 8'd4; i_arr[1] = 8'd5;
      w_arr[2] = 8'd1; i_arr[2] = 8'd1;
      do_job(3, 32'd10, 0, 0, 0, 0);

      // Empty job returns bias the cycle after start.
      do_job(0, 32'h1234, 0, 0, 1, 2);

      // Single beat that wraps the accumulator.
      w_arr[0] = 8'd255; i_arr[0] = 8'd255;
      do_job(1, 32'hFFFF_FFF0, 0, 0, 0, 1);

      // Long idle gaps between beats, then a stalled consumer.
      w_arr[0] = 8'd7; i_arr[0] = 8'd9;
      w_arr[1] = 8'd11; i_arr[1] = 8'd13;
      do_job(2, 32'd100, 5, 5, 4, 4);

      // Reset mid-run aborts the job with no result.
      start = 1'b1; len = 8'd3; bias = 32'd77;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; weight = 8'd2; inp = 8'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_outputs", {busy, in_ready, out_valid, ovf, result}, 36'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      w_arr[0] = 8'd3; i_arr[0] = 8'd3;
      do_job(1, 32'd0, 0, 1, 0, 1);

      // Maximum length without counter wrap.
      for (int k = 0; k < 256; k++) begin
         w_arr[k] = 8'd1;
         i_arr[k] = 8'd1;
      end
      do_job(255, 32'd5000, 0, 0, 0, 0);

      // Random jobs, some with biases near the top to provoke wraps.
      for (int j = 0; j < 10; j++) begin
         int          n;
         logic [31:0] b;
         n = int'($urandom_range(12, 0));
         b = (j % 3 == 0) ? (32'hFFFF_0000 | 32'($urandom_range(65535, 0))) : $urandom;
         for (int k = 0; k < n; k++) begin
            w_arr[k] = 8'($urandom);
            i_arr[k] = 8'($urandom);
         end
         do_job(n, b, 0, 2, 0, 3);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width of weight and inp.
REQ-002 Parameter ACCWIDTH, default 32, accumulator and result width.
REQ-003 Parameter LENW, default 8, width of the vector-length field.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a dot product; sampled only in IDLE.
REQ-007 len  input  LENW  number of operand pairs; sampled with start.
REQ-008 bias  input  ACCWIDTH  initial partial sum; sampled with start.
REQ-009 in_valid  input  1  weight/inp pair valid.
REQ-010 in_ready  output  1  block accepts a pair this cycle.
REQ-011 weight  input  WIDTH  unsigned weight operand.
REQ-012 inp  input  WIDTH  unsigned activation operand.
REQ-013 out_valid  output  1  result and ovf valid.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 result  output  ACCWIDTH  final accumulated sum.
REQ-016 ovf  output  1  sticky flag: the accumulation wrapped at least once this job.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
REQ-019 In IDLE with start=1, the block SHALL load acc<=bias, cnt<=len and ovf<=0.
REQ-020 In IDLE with start=1, the next state SHALL be DONE if len==0, else RUN.
REQ-021 A start asserted outside IDLE SHALL be ignored with no side effect.
REQ-022 in_ready SHALL be 1 only in RUN and SHALL depend only on state, never on in_valid.
REQ-023 A beat SHALL be accepted only on a cycle with in_valid&in_ready.
REQ-024 Per accepted beat: acc<=(acc + weight*inp) mod 2^ACCWIDTH; cnt<=cnt-1.
REQ-025 The product SHALL be formed at 2*WIDTH bits and zero-extended before the add.
REQ-026 ovf SHALL be set when an accumulation carries out of bit ACCWIDTH-1, and held until the next accepted start.
REQ-027 The beat accepted with cnt==1 SHALL move the FSM to DONE; no further beats are accepted.
REQ-028 In RUN with in_valid=0, the FSM SHALL hold acc and cnt unchanged, for an unbounded number of cycles.
REQ-029 out_valid SHALL be 1 exactly in DONE; result=acc and ovf SHALL be stable while out_valid=1.
REQ-030 Latency: out_valid SHALL rise on the cycle after the last beat is accepted (len>=1), or the cycle after start (len==0).
REQ-031 In DONE with out_ready=1, the FSM SHALL return to IDLE next cycle.
REQ-032 In DONE with out_ready=0, the FSM SHALL hold DONE indefinitely.
REQ-033 A start in the same cycle as the DONE-to-IDLE transition SHALL be ignored; start is honoured only when already in IDLE.
REQ-034 len==2^LENW-1 SHALL be supported without counter wrap.

Reset
REQ-035 On rst_n=0, the FSM SHALL go to IDLE immediately, regardless of clock.
REQ-036 On rst_n=0, acc, cnt and ovf SHALL clear to 0.
REQ-037 During and after reset until a start: in_ready=0, out_valid=0, busy=0, result=0 and ovf=0.
REQ-038 Reset during RUN or DONE SHALL abort the job; no result is produced for it.

Structure
REQ-039 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH, ACCWIDTH and LENW constants.
REQ-040 The combinational multiply-accumulate SHALL be one sub-module, mac_dp, with inputs weight, inp and acc and outputs sum and carry; mac_seq holds all state.

Verification
REQ-041 Set bias=10, len=3; send pairs (2,3),(4,5),(1,1) back-to-back -> result=37, ovf=0, out_valid rises one cycle after the third beat.
REQ-042 Set len=0, bias=0x1234 -> out_valid rises the cycle after start, with result=0x1234; in_ready stays 0.
REQ-043 Set bias=0xFFFFFFF0, len=1; send (255,255) -> result=0x0000FDF1, ovf=1.
REQ-044 Set len=2; insert 5 idle cycles between beats, then hold out_ready=0 for 4 cycles -> acc holds during the gap; result is stable and start is ignored while in DONE.
REQ-045 Pulse rst_n low mid-RUN after 1 of 3 beats -> busy, in_ready and out_valid go to 0 at once; a following job with len=1, bias=0 and pair (3,3) yields result=9.
REQ-046 Set len=255; send all pairs as (1,1) -> result=bias+255, and exactly 255 beats are accepted.
